// File: rtl/tx_frame_buffer_if.sv
// Bundle of writer, frame-FSM handshake and status signals around tx_frame_buffer.
// The buffer attaches through the slave modport; the DAQ writer / frame FSM side uses master.
interface tx_frame_buffer_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          WR_EN;
  logic [DW-1:0] WR_DATA;
  logic          WR_LAST;
  logic          WR_RDY;
  logic          TX_ACK;
  logic [3:0]    FRM_STATE;
  logic          VALID;
  logic [DW-1:0] TXD;
  logic          OVFL_ERR;
  logic          RUNT_ERR;
  logic [AW:0]   FRM_LEN;

  modport master (
    output WR_EN, WR_DATA, WR_LAST, TX_ACK, FRM_STATE,
    input  WR_RDY, VALID, TXD, OVFL_ERR, RUNT_ERR, FRM_LEN
  );

  modport slave (
    input  WR_EN, WR_DATA, WR_LAST, TX_ACK, FRM_STATE,
    output WR_RDY, VALID, TXD, OVFL_ERR, RUNT_ERR, FRM_LEN
  );
endinterface

// File: rtl/tx_frame_buffer.sv
// Single-frame transmit buffer feeding the GbE frame FSM: fill, request (VALID), stream on TXD.
// Optional macro TX_FRM_BUF_TMR_EN triplicates and majority-votes the control registers.
module tx_frame_buffer #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic           CLK,
  input  logic           RST_N,
  tx_frame_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    REQ       = 2'd1,
    SEND      = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW-1:0] PTR_MAX  = {AW{1'b1}};
  localparam logic [AW:0]   LEN_ONE  = (AW + 1)'(1'b1);

  // Voted (or single-copy) view of the protected control registers
  state_t        state_s;
  logic [AW-1:0] wr_ptr_s;
  logic [AW-1:0] rd_ptr_s;
  logic          valid_s;
  logic          wr_rdy_s;

  state_t        state_d;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] rd_ptr_d;
  logic          valid_d;
  logic          wr_rdy_d;

  logic [DW-1:0] txd_d,     txd_q;
  logic          ovfl_d,    ovfl_q;
  logic          runt_d,    runt_q;
  logic [AW:0]   frm_len_d, frm_len_q;

  logic [DW-1:0] mem_q [2**AW];
  logic          wr_accept_s;

`ifdef TX_FRM_BUF_TMR_EN
  function automatic logic maj1(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [1:0] maj2(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [AW-1:0] majp(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                         input logic [AW-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0]    state_c0_q,  state_c1_q,  state_c2_q;
  logic [AW-1:0] wr_ptr_c0_q, wr_ptr_c1_q, wr_ptr_c2_q;
  logic [AW-1:0] rd_ptr_c0_q, rd_ptr_c1_q, rd_ptr_c2_q;
  logic          valid_c0_q,  valid_c1_q,  valid_c2_q;
  logic          wr_rdy_c0_q, wr_rdy_c1_q, wr_rdy_c2_q;

  assign state_s  = state_t'(maj2(state_c0_q, state_c1_q, state_c2_q));
  assign wr_ptr_s = majp(wr_ptr_c0_q, wr_ptr_c1_q, wr_ptr_c2_q);
  assign rd_ptr_s = majp(rd_ptr_c0_q, rd_ptr_c1_q, rd_ptr_c2_q);
  assign valid_s  = maj1(valid_c0_q, valid_c1_q, valid_c2_q);
  assign wr_rdy_s = maj1(wr_rdy_c0_q, wr_rdy_c1_q, wr_rdy_c2_q);

  // All three copies reload from the voted next state, so a single upset is scrubbed in one clock
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_c0_q  <= FILL;     state_c1_q  <= FILL;     state_c2_q  <= FILL;
      wr_ptr_c0_q <= PTR_ZERO; wr_ptr_c1_q <= PTR_ZERO; wr_ptr_c2_q <= PTR_ZERO;
      rd_ptr_c0_q <= PTR_ZERO; rd_ptr_c1_q <= PTR_ZERO; rd_ptr_c2_q <= PTR_ZERO;
      valid_c0_q  <= 1'b0;     valid_c1_q  <= 1'b0;     valid_c2_q  <= 1'b0;
      wr_rdy_c0_q <= 1'b1;     wr_rdy_c1_q <= 1'b1;     wr_rdy_c2_q <= 1'b1;
    end else begin
      state_c0_q  <= state_d;  state_c1_q  <= state_d;  state_c2_q  <= state_d;
      wr_ptr_c0_q <= wr_ptr_d; wr_ptr_c1_q <= wr_ptr_d; wr_ptr_c2_q <= wr_ptr_d;
      rd_ptr_c0_q <= rd_ptr_d; rd_ptr_c1_q <= rd_ptr_d; rd_ptr_c2_q <= rd_ptr_d;
      valid_c0_q  <= valid_d;  valid_c1_q  <= valid_d;  valid_c2_q  <= valid_d;
      wr_rdy_c0_q <= wr_rdy_d; wr_rdy_c1_q <= wr_rdy_d; wr_rdy_c2_q <= wr_rdy_d;
    end
  end
`else
  state_t        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic          valid_q;
  logic          wr_rdy_q;

  assign state_s  = state_q;
  assign wr_ptr_s = wr_ptr_q;
  assign rd_ptr_s = rd_ptr_q;
  assign valid_s  = valid_q;
  assign wr_rdy_s = wr_rdy_q;

  // Single-copy control registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= FILL;
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      valid_q  <= 1'b0;
      wr_rdy_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      wr_rdy_q <= wr_rdy_d;
    end
  end
`endif

  assign wr_accept_s = bus.WR_EN & wr_rdy_s & (state_s == FILL);

  // Payload storage; stale contents are harmless because the pointers define the frame
  always_ff @(posedge CLK) begin
    if (wr_accept_s) begin
      mem_q[wr_ptr_s] <= bus.WR_DATA;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_s;
    wr_ptr_d  = wr_ptr_s;
    rd_ptr_d  = rd_ptr_s;
    valid_d   = valid_s;
    wr_rdy_d  = wr_rdy_s;
    txd_d     = txd_q;
    ovfl_d    = ovfl_q;
    runt_d    = 1'b0;
    frm_len_d = frm_len_q;

    case (state_s)
      FILL: begin
        wr_rdy_d = 1'b1;
        valid_d  = 1'b0;
        rd_ptr_d = PTR_ZERO;
        if (wr_accept_s) begin
          if (bus.WR_LAST) begin
            if (wr_ptr_s == PTR_ZERO) begin
              runt_d   = 1'b1;
              wr_ptr_d = PTR_ZERO;
            end else begin
              frm_len_d = {1'b0, wr_ptr_s} + LEN_ONE;
              wr_ptr_d  = PTR_ZERO;
              wr_rdy_d  = 1'b0;
              valid_d   = 1'b1;
              state_d   = REQ;
            end
          end else if (wr_ptr_s == PTR_MAX) begin
            ovfl_d   = 1'b1;
            wr_ptr_d = PTR_ZERO;
          end else begin
            wr_ptr_d = wr_ptr_s + PTR_ONE;
          end
        end else begin
          wr_ptr_d = wr_ptr_s;
        end
      end

      REQ: begin
        // Word 0 is preloaded every REQ cycle so an ack on the first cycle still finds it ready
        wr_rdy_d = 1'b0;
        valid_d  = 1'b1;
        txd_d    = mem_q[PTR_ZERO];
        rd_ptr_d = PTR_ONE;
        if (bus.TX_ACK) begin
          state_d = SEND;
        end else begin
          state_d = REQ;
        end
      end

      SEND: begin
        // VALID already low means the final word is on TXD this cycle
        wr_rdy_d = 1'b0;
        if (valid_s) begin
          txd_d    = mem_q[rd_ptr_s];
          rd_ptr_d = rd_ptr_s + PTR_ONE;
          valid_d  = (({1'b0, rd_ptr_s} + LEN_ONE) < frm_len_q);
        end else begin
          txd_d   = {DW{1'b0}};
          valid_d = 1'b0;
          state_d = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        valid_d  = 1'b0;
        wr_rdy_d = 1'b0;
        if (bus.FRM_STATE == 4'b0000) begin
          wr_rdy_d = 1'b1;
          wr_ptr_d = PTR_ZERO;
          state_d  = FILL;
        end else begin
          state_d = WAIT_IDLE;
        end
      end

      default: begin
        state_d  = FILL;
        wr_ptr_d = PTR_ZERO;
        rd_ptr_d = PTR_ZERO;
        valid_d  = 1'b0;
        wr_rdy_d = 1'b1;
        txd_d    = {DW{1'b0}};
      end
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      txd_q     <= {DW{1'b0}};
      ovfl_q    <= 1'b0;
      runt_q    <= 1'b0;
      frm_len_q <= {(AW + 1){1'b0}};
    end else begin
      txd_q     <= txd_d;
      ovfl_q    <= ovfl_d;
      runt_q    <= runt_d;
      frm_len_q <= frm_len_d;
    end
  end

  assign bus.WR_RDY   = wr_rdy_s;
  assign bus.VALID    = valid_s;
  assign bus.TXD      = txd_q;
  assign bus.OVFL_ERR = ovfl_q;
  assign bus.RUNT_ERR = runt_q;
  assign bus.FRM_LEN  = frm_len_q;

endmodule
